// File: rtl/vga_color_dither_stage.sv
// vga_color_dither_stage: 2-stage VGA colour reduction, syncs aligned to pixels.
// Define COLOR_DITHER_TEST_PATTERN_EN to add test_en and an 8-bar colour pattern.
module vga_dither_chan #(
  parameter int W     = 5,
  parameter int OUT_W = 2
) (
  input  logic [W-1:0]     c,
  input  logic [3:0]       bay,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] o
);
  if (W <= OUT_W) begin : g_wide
    logic unused_ok;
    assign unused_ok = ^{bay, mode};
    assign o = OUT_W'(c) << (OUT_W - W);
  end else begin : g_narrow
    localparam int D = W - OUT_W;
    logic [W:0]       t;
    logic [W:0]       sum;
    logic [OUT_W:0]   q;
    logic [OUT_W-1:0] trunc;
    logic [OUT_W-1:0] legacy;
    logic [OUT_W-1:0] dith;

    if (D >= 4) begin : g_tshl
      assign t = (W+1)'(bay) << (D - 4);
    end else begin : g_tshr
      logic [3:0] bs;
      assign bs = bay >> (4 - D);
      assign t  = (W+1)'(bs);
    end

    assign sum   = {1'b0, c} + t;
    assign q     = sum[W:D];
    assign dith  = q[OUT_W] ? '1 : q[OUT_W-1:0];
    assign trunc = c[W-1 -: OUT_W];

    if (OUT_W == 1) begin : g_l1
      assign legacy = |c;
    end else begin : g_ln
      assign legacy = {c[W-1 -: OUT_W-1], |c[D:0]};
    end

    always_comb begin
      case (mode)
        2'd0:    o = trunc;
        2'd1:    o = legacy;
        default: o = dith;
      endcase
    end
  end
endmodule

module vga_color_dither_stage #(
  parameter int R_W         = 5,
  parameter int G_W         = 6,
  parameter int B_W         = 5,
  parameter int OUT_W       = 2,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic             display_on,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [1:0]       x,
  input  logic [1:0]       y,
  input  logic [R_W-1:0]   red,
  input  logic [G_W-1:0]   green,
  input  logic [B_W-1:0]   blue,
`ifdef COLOR_DITHER_TEST_PATTERN_EN
  input  logic             test_en,
`endif
  output logic [OUT_W-1:0] vga_red,
  output logic [OUT_W-1:0] vga_green,
  output logic [OUT_W-1:0] vga_blue,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic [1:0]       frame_cnt
);
  localparam logic SA = SYNC_ACTIVE;

  logic [1:0]     act_mode;
  logic           vs_prev;
  logic           frame_edge;
  logic [1:0]     xi, yi;
  logic [3:0]     bay;
  logic [R_W-1:0] r_in, r1;
  logic [G_W-1:0] g_in, g1;
  logic [B_W-1:0] b_in, b1;
  logic [3:0]     bay1;
  logic [1:0]     m1;
  logic           d1, hs1, vs1;
  logic [OUT_W-1:0] ro, go, bo;

  assign frame_edge = (vsync_in == SA) && (vs_prev != SA);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev   <= ~SA;
      frame_cnt <= 2'd0;
      act_mode  <= 2'd1;
    end else begin
      vs_prev <= vsync_in;
      if (frame_edge) begin
        frame_cnt <= frame_cnt + 2'd1;
        act_mode  <= mode;
      end
    end
  end

  // Temporal mode rotates the Bayer index by the frame count.
  always_comb begin
    xi = x;
    yi = y;
    if (act_mode == 2'd3) begin
      xi = x + {frame_cnt[0], 1'b0};
      yi = y + {frame_cnt[1], 1'b0};
    end
  end

  always_comb begin
    bay = 4'd0;
    case ({yi, xi})
      4'h0: bay = 4'd0;
      4'h1: bay = 4'd8;
      4'h2: bay = 4'd2;
      4'h3: bay = 4'd10;
      4'h4: bay = 4'd12;
      4'h5: bay = 4'd4;
      4'h6: bay = 4'd14;
      4'h7: bay = 4'd6;
      4'h8: bay = 4'd3;
      4'h9: bay = 4'd11;
      4'ha: bay = 4'd1;
      4'hb: bay = 4'd9;
      4'hc: bay = 4'd15;
      4'hd: bay = 4'd7;
      4'he: bay = 4'd13;
      4'hf: bay = 4'd5;
      default: bay = 4'd0;
    endcase
  end

`ifdef COLOR_DITHER_TEST_PATTERN_EN
  logic [1:0] pix_cnt;
  logic [2:0] bar;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt <= 2'd0;
      bar     <= 3'd0;
    end else if (hsync_in == SA) begin
      pix_cnt <= 2'd0;
      bar     <= 3'd0;
    end else if (display_on) begin
      pix_cnt <= pix_cnt + 2'd1;
      if (pix_cnt == 2'd3) bar <= bar + 3'd1;
    end
  end

  always_comb begin
    r_in = red;
    g_in = green;
    b_in = blue;
    if (test_en) begin
      r_in = {R_W{bar[2]}};
      g_in = {G_W{bar[1]}};
      b_in = {B_W{bar[0]}};
    end
  end
`else
  assign r_in = red;
  assign g_in = green;
  assign b_in = blue;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r1   <= '0;
      g1   <= '0;
      b1   <= '0;
      bay1 <= 4'd0;
      m1   <= 2'd1;
      d1   <= 1'b0;
      hs1  <= ~SA;
      vs1  <= ~SA;
    end else begin
      r1   <= r_in;
      g1   <= g_in;
      b1   <= b_in;
      bay1 <= bay;
      m1   <= act_mode;
      d1   <= display_on;
      hs1  <= hsync_in;
      vs1  <= vsync_in;
    end
  end

  vga_dither_chan #(.W(R_W), .OUT_W(OUT_W)) u_r (
    .c(r1), .bay(bay1), .mode(m1), .o(ro)
  );
  vga_dither_chan #(.W(G_W), .OUT_W(OUT_W)) u_g (
    .c(g1), .bay(bay1), .mode(m1), .o(go)
  );
  vga_dither_chan #(.W(B_W), .OUT_W(OUT_W)) u_b (
    .c(b1), .bay(bay1), .mode(m1), .o(bo)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vga_red   <= '0;
      vga_green <= '0;
      vga_blue  <= '0;
      vga_hsync <= ~SA;
      vga_vsync <= ~SA;
    end else begin
      vga_red   <= d1 ? ro : '0;
      vga_green <= d1 ? go : '0;
      vga_blue  <= d1 ? bo : '0;
      vga_hsync <= hs1;
      vga_vsync <= vs1;
    end
  end
endmodule
